// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared state encoding and slot geometry for the TDM demultiplexer
package tdm_demux_pkg;
  typedef enum logic {IDLE, COLLECT} state_e;
  localparam int SLOTS = 4;
  localparam int SLOT_W = 2;
endpackage

// File: rtl/tdm_slot_decoder.sv
// tdm_slot_decoder: enabled 2-to-4 one-hot decoder turning a slot number into lane-buffer write enables
module tdm_slot_decoder
  import tdm_demux_pkg::*;
(
  input  logic [SLOT_W-1:0] slot_i,
  input  logic              en_i,
  output logic [SLOTS-1:0]  we_o
);
  // exactly one enable for the addressed slot, none when no beat is accepted
  always_comb we_o = en_i ? (SLOTS'(1) << slot_i) : '0;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: registered 1-to-4 TDM demultiplexer; TDM_DEMUX_PARITY_EN adds per-beat even-parity checking
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             frame_start,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             in_parity,
`endif
  input  logic [WIDTH-1:0] in_data,
  output logic             address0,
  output logic             address1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             frame_err
);
  state_e                        state_q, state_d;
  logic [SLOT_W-1:0]             slot_q, slot_d, dec_slot;
  logic [2:0][WIDTH-1:0]         buf_q, buf_d;
  logic [SLOTS-1:0][WIDTH-1:0]   lane_q, lane_d;
  logic                          bad_q, bad_d, valid_q, valid_d, err_q, err_d;
  logic                          start, cont, complete, par_err, frame_bad;
  logic [SLOTS-1:0]              we;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err = ^{in_data, in_parity};
`else
  assign par_err = 1'b0;
`endif
  // a frame_start beat always lands in slot 0, overriding any partial frame
  always_comb begin
    start    = in_valid & frame_start;
    cont     = in_valid & ~frame_start & (state_q == COLLECT);
    dec_slot = start ? '0 : slot_q;
  end
  tdm_slot_decoder u_dec (
    .slot_i (dec_slot),
    .en_i   (start | cont),
    .we_o   (we)
  );
  // next-state: buffer writes, slot advance, atomic publish on slot 3, error pulses
  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < 3; i++) if (we[i]) buf_d[i] = in_data;
    complete  = we[3];
    frame_bad = start ? par_err : (bad_q | par_err);
    bad_d     = complete ? 1'b0 : (start | cont) ? frame_bad : bad_q;
    valid_d   = complete & ~frame_bad;
    lane_d    = valid_d ? {in_data, buf_q[2], buf_q[1], buf_q[0]} : lane_q;
    err_d     = (start & (state_q == COLLECT)) | (complete & frame_bad);
    state_d   = start ? COLLECT : complete ? IDLE : state_q;
    slot_d    = start ? SLOT_W'(1) : cont ? slot_q + 1'b1 : slot_q;
  end
  // state register; reset drops any partial frame without raising an error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      buf_q   <= '0;
      lane_q  <= '0;
      bad_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
      lane_q  <= lane_d;
      bad_q   <= bad_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign address0  = slot_q[0];
  assign address1  = slot_q[1];
  assign out0      = lane_q[0];
  assign out1      = lane_q[1];
  assign out2      = lane_q[2];
  assign out3      = lane_q[3];
  assign out_valid = valid_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed stimulus with a scoreboard queue of expected out_valid/frame_err pulses
module tb_tdm_demux;
  localparam int W = 8;
  logic         clk = 1'b0, reset = 1'b0, in_valid = 1'b0, frame_start = 1'b0;
  logic [W-1:0] in_data = '0;
`ifdef TDM_DEMUX_PARITY_EN
  logic         in_parity = 1'b0;
`endif
  logic         address0, address1, out_valid, frame_err;
  logic [W-1:0] out0, out1, out2, out3;
  int           checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic         v;
    logic [4*W-1:0] lanes;
    int           at;
  } ev_t;
  ev_t q[$];
  ev_t e;

  tdm_demux #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .frame_start (frame_start),
`ifdef TDM_DEMUX_PARITY_EN
    .in_parity   (in_parity),
`endif
    .in_data     (in_data),
    .address0    (address0),
    .address1    (address1),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out_valid   (out_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*W-1:0] pack(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] l0, l1, l2, l3);
    q.push_back('{1'b1, pack(l0, l1, l2, l3), cyc + 1});
  endtask

  task automatic push_err();
    q.push_back('{1'b0, '0, cyc + 1});
  endtask

  task automatic send(input logic [W-1:0] d, input logic fs, input int exp_addr, input logic bad = 1'b0);
    chk("address", 64'({address1, address0}), 64'(exp_addr));
    in_valid = 1'b1;
    frame_start = fs;
    in_data = d;
`ifdef TDM_DEMUX_PARITY_EN
    in_parity = (^d) ^ bad;
`else
    if (bad) $display("note: parity flip ignored in this build");
`endif
    @(negedge clk);
    in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // monitor: every pulse must match the head of the scoreboard in kind, cycle and lanes
  always @(negedge clk) begin
    if (!reset && (out_valid || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got valid=%0b err=%0b expected none", out_valid, frame_err);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 64'({out_valid, frame_err}), 64'({e.v, ~e.v}));
        chk("pulse_cycle", 64'(cyc), 64'(e.at));
        if (e.v) chk("pulse_lanes", 64'(pack(out0, out1, out2, out3)), 64'(e.lanes));
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset_ctl", 64'({address1, address0, out_valid, frame_err}), 64'd0);
    chk("reset_lanes", 64'(pack(out0, out1, out2, out3)), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h5A, 1'b0, 0);
    send(8'h01, 1'b1, 0);
    send(8'h00, 1'b0, 1);
    send(8'h01, 1'b0, 2);
    push_frame(8'h01, 8'h00, 8'h01, 8'h01);
    send(8'h01, 1'b0, 3);
    chk("addr_wrap", 64'({address1, address0}), 64'd0);
    idle(2);
    send(8'h01, 1'b1, 0);
    send(8'h00, 1'b0, 1);
    idle(3);
    chk("stall_lanes_hold", 64'(pack(out0, out1, out2, out3)), 64'(pack(8'h01, 8'h00, 8'h01, 8'h01)));
    send(8'h01, 1'b0, 2);
    push_frame(8'h01, 8'h00, 8'h01, 8'h01);
    send(8'h01, 1'b0, 3);
    idle(2);
    send(8'hA1, 1'b1, 0);
    send(8'hB2, 1'b0, 1);
    push_err();
    send(8'hC3, 1'b1, 2);
    send(8'hD4, 1'b0, 1);
    send(8'hE5, 1'b0, 2);
    push_frame(8'hC3, 8'hD4, 8'hE5, 8'hF6);
    send(8'hF6, 1'b0, 3);
    idle(2);
    chk("abort_lanes", 64'(pack(out0, out1, out2, out3)), 64'(pack(8'hC3, 8'hD4, 8'hE5, 8'hF6)));
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b0, 1);
    send(8'h33, 1'b0, 2);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    send(8'h44, 1'b0, 3);
    send(8'h55, 1'b1, 0);
    send(8'h66, 1'b0, 1);
    send(8'h77, 1'b0, 2);
    push_frame(8'h55, 8'h66, 8'h77, 8'h88);
    send(8'h88, 1'b0, 3);
    idle(2);
    chk("b2b_lanes", 64'(pack(out0, out1, out2, out3)), 64'(pack(8'h55, 8'h66, 8'h77, 8'h88)));
`ifdef TDM_DEMUX_PARITY_EN
    send(8'h9A, 1'b1, 0);
    send(8'h9B, 1'b0, 1, 1'b1);
    send(8'h9C, 1'b0, 2);
    push_err();
    send(8'h9D, 1'b0, 3);
    idle(2);
    chk("parity_lanes_hold", 64'(pack(out0, out1, out2, out3)), 64'(pack(8'h55, 8'h66, 8'h77, 8'h88)));
    send(8'h10, 1'b1, 0);
    push_err();
    send(8'h20, 1'b1, 1, 1'b1);
    send(8'h21, 1'b0, 1);
    send(8'h22, 1'b0, 2);
    push_err();
    send(8'h23, 1'b0, 3);
    idle(2);
    chk("abort_parity_lanes", 64'(pack(out0, out1, out2, out3)), 64'(pack(8'h55, 8'h66, 8'h77, 8'h88)));
`endif
    send(8'h31, 1'b1, 0);
    send(8'h32, 1'b0, 1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_ctl", 64'({address1, address0, out_valid, frame_err}), 64'd0);
    chk("midreset_lanes", 64'(pack(out0, out1, out2, out3)), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h41, 1'b0, 0);
    send(8'h01, 1'b1, 0);
    send(8'h02, 1'b0, 1);
    send(8'h03, 1'b0, 2);
    push_frame(8'h01, 8'h02, 8'h03, 8'h04);
    send(8'h04, 1'b0, 3);
    idle(4);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
